// File: rtl/jacobi_input_loader.sv
// -----------------------------------------------------------------------------
// jacobi_input_loader
//
// Front end of the Jacobi eigen-solver. Streams the packed upper triangle of a
// symmetric NxN matrix (row-major: (0,0),(0,1)..(0,N-1),(1,1)..(N-1,N-1)) into
// the working memory at addresses 0..N_IN-1. Each word is sign-extended from
// Q(1.0.15) to Q(1.4.15). The NxN identity matrix is then written into the
// eigenvector region V_OFFSET..V_OFFSET+N*N-1. Finally `done` pulses so the
// sweep controller can start rotating.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        single-cycle request to load a new matrix (honoured in IDLE)
//   in_dat       signed input element, Q(1.0.15)
//   in_valid     in_dat is valid
//   in_ready     loader accepts in_dat this cycle (high for the whole LOAD_A)
//   mem_wr_en    registered memory write strobe
//   mem_wr_addr  registered write address
//   mem_wr_dat   registered write data, Q(1.4.15)
//   busy         high from the cycle after start through the done cycle
//   done         one-cycle pulse, the cycle after the last V write
// -----------------------------------------------------------------------------
module jacobi_input_loader #(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 20,
  parameter int N        = 8,
  parameter int N_IN     = 36,
  parameter int V_OFFSET = 36,
  parameter int ADDR_W   = 7,
  parameter int FRAC     = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic signed [IN_W-1:0]   in_dat,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     mem_wr_en,
  output logic        [ADDR_W-1:0] mem_wr_addr,
  output logic signed [OUT_W-1:0]  mem_wr_dat,
  output logic                     busy,
  output logic                     done
);

  localparam int LOG2N = $clog2(N);
  localparam int A_CW  = $clog2(N_IN);
  localparam int V_CW  = 2 * LOG2N;

  localparam logic [A_CW-1:0] A_LAST = A_CW'(N_IN - 1);
  localparam logic [V_CW-1:0] V_LAST = V_CW'(N * N - 1);
  localparam logic signed [OUT_W-1:0] ONE_Q = OUT_W'(2 ** FRAC);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_A = 2'd1,
    INIT_V = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [A_CW-1:0] a_cnt;
  logic [V_CW-1:0] v_cnt;
  logic            accept;
  logic            cnt_clr;

  logic                     wr_vld_p1;
  logic        [ADDR_W-1:0] wr_addr_p1;
  logic signed [OUT_W-1:0]  wr_dat_p1;
  logic                     busy_p1;
  logic                     done_p1;

  // Widen a Q(1.0.15) word to Q(1.4.15): integer bits grow, FRAC unchanged.
  function automatic logic signed [OUT_W-1:0] sext_q(input logic signed [IN_W-1:0] d);
    sext_q = {{(OUT_W-IN_W){d[IN_W-1]}}, d};
  endfunction

  // Identity element for flat V index: row = upper bits, column = lower bits.
  function automatic logic signed [OUT_W-1:0] eye_q(input logic [V_CW-1:0] idx);
    logic [LOG2N-1:0] r;
    logic [LOG2N-1:0] c;
    r = idx[V_CW-1:LOG2N];
    c = idx[LOG2N-1:0];
    eye_q = (r == c) ? ONE_Q : '0;
  endfunction

  // -------------------------------------------------------------------------
  // Stage p0: state register and element counters
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // in_ready depends on state only, so it never loops back through in_valid.
  // A start arriving while the done pulse is still on the port is dropped,
  // so a new load begins no earlier than the cycle after done.
  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    accept   = 1'b0;
    cnt_clr  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !done) begin
          state_nx = LOAD_A;
          cnt_clr  = 1'b1;
        end
      end
      LOAD_A: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid && (a_cnt == A_LAST)) begin
          state_nx = INIT_V;
        end
      end
      INIT_V: begin
        if (v_cnt == V_LAST) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_cnt <= '0;
      v_cnt <= '0;
    end else if (cnt_clr) begin
      a_cnt <= '0;
      v_cnt <= '0;
    end else begin
      if (accept) begin
        a_cnt <= a_cnt + 1'b1;
      end
      if (state == INIT_V) begin
        v_cnt <= v_cnt + 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stage p1: registered memory write port and status flags
  // -------------------------------------------------------------------------
  // Address/data only update on a real write; they hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_vld_p1  <= 1'b0;
      wr_addr_p1 <= '0;
      wr_dat_p1  <= '0;
    end else begin
      wr_vld_p1 <= accept || (state == INIT_V);
      if (accept) begin
        wr_addr_p1 <= ADDR_W'(a_cnt);
        wr_dat_p1  <= sext_q(in_dat);
      end else if (state == INIT_V) begin
        wr_addr_p1 <= ADDR_W'(V_OFFSET) + ADDR_W'(v_cnt);
        wr_dat_p1  <= eye_q(v_cnt);
      end
    end
  end

  // DONE state lasts one cycle and is seen on the port one cycle later, right
  // after the last V write; busy is stretched over that same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_p1 <= 1'b0;
      done_p1 <= 1'b0;
    end else begin
      busy_p1 <= (state_nx != IDLE) || (state == DONE);
      done_p1 <= (state == DONE);
    end
  end

  assign mem_wr_en   = wr_vld_p1;
  assign mem_wr_addr = wr_addr_p1;
  assign mem_wr_dat  = wr_dat_p1;
  assign busy        = busy_p1;
  assign done        = done_p1;

endmodule
